// File: rtl/pattern_1010.sv
// Moore detector for serial 1,0,1,0; PDET is registered and rises one cycle after the edge sampling the final 0.
// No backpressure and no enable: every rising edge with SCLR high consumes one IN_DATA bit.
module pattern_1010 #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic CLK,
    input  logic SCLR,
    input  logic IN_DATA,
    output logic PDET
);

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1010 = 3'd4
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   pdet_q;
    logic   pdet_d;

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:    state_d = IN_DATA ? S1   : S0;
            S1:    state_d = IN_DATA ? S1   : S10;
            S10:   state_d = IN_DATA ? S101 : S0;
            S101:  state_d = IN_DATA ? S1   : S1010;
            // With overlap the trailing "10" of a match already counts as a "10" prefix.
            S1010: state_d = IN_DATA ? (OVERLAP ? S101 : S1) : S0;
            default: state_d = S0;
        endcase
        pdet_d = (state_d == S1010);
    end

    always_ff @(posedge CLK) begin
        if (!SCLR) begin
            state_q <= S0;
            pdet_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pdet_q  <= pdet_d;
        end
    end

    assign PDET = pdet_q;

endmodule

// File: tb/tb_pattern_1010.sv
// Bench for pattern_1010: directed vector table for both overlap modes, then random stream vs a window model.
module tb_pattern_1010;

    logic clk;
    logic sclr;
    logic in_data;
    logic pdet_ov;
    logic pdet_no;

    int total;
    int bad;

    pattern_1010 #(.OVERLAP(1'b1)) dut_ov (
        .CLK     (clk),
        .SCLR    (sclr),
        .IN_DATA (in_data),
        .PDET    (pdet_ov)
    );

    pattern_1010 #(.OVERLAP(1'b0)) dut_no (
        .CLK     (clk),
        .SCLR    (sclr),
        .IN_DATA (in_data),
        .PDET    (pdet_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic sclr;
        logic din;
        logic exp_ov;
        logic exp_no;
    } vec_t;

    vec_t vecs[$];

    // Reference: last four bits seen since the stream (re)started, plus how many were seen.
    logic [3:0] win_ov;
    int         len_ov;
    logic [3:0] win_no;
    int         len_no;
    logic       mdl_ov;
    logic       mdl_no;

    function automatic vec_t mk(input logic s, input logic d, input logic eo, input logic en);
        vec_t v;
        v.sclr   = s;
        v.din    = d;
        v.exp_ov = eo;
        v.exp_no = en;
        return v;
    endfunction

    task automatic add_bits(input string bits, input string hits_ov, input string hits_no);
        for (int i = 0; i < bits.len(); i++)
            vecs.push_back(mk(1'b1, bits[i] == "1", hits_ov[i] == "1", hits_no[i] == "1"));
    endtask

    task automatic model_step(input logic s, input logic d);
        if (!s) begin
            len_ov = 0;
            len_no = 0;
            mdl_ov = 1'b0;
            mdl_no = 1'b0;
        end else begin
            win_ov = {win_ov[2:0], d};
            len_ov++;
            mdl_ov = (len_ov >= 4) && (win_ov == 4'b1010);
            win_no = {win_no[2:0], d};
            len_no++;
            mdl_no = (len_no >= 4) && (win_no == 4'b1010);
            if (mdl_no) len_no = 0;
        end
    endtask

    task automatic apply(input logic s, input logic d);
        @(negedge clk);
        sclr    = s;
        in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s idx=%0d pdet=%0b expected=%0b", name, idx, got, want);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        sclr    = 1'b0;
        in_data = 1'b0;
        win_ov  = '0;
        win_no  = '0;
        len_ov  = 0;
        len_no  = 0;
        mdl_ov  = 1'b0;
        mdl_no  = 1'b0;

        // Reset held two edges with data toggling.
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        // Single match.
        add_bits("001010", "000001", "000001");
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        // Mixed stream: overlap hits at bits 12 and 14, non-overlap only at 12.
        add_bits("0010110011010101100",
                 "0000000000001010000",
                 "0000000000001000000");
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        // Near misses.
        add_bits("1101100100", "0000000000", "0000000000");
        // Reset mid-pattern discards the partial "101".
        add_bits("101", "000", "000");
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        add_bits("0", "0", "0");
        add_bits("1010", "0001", "0001");
        // Reset while PDET is high.
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        // Back-to-back overlapping matches two cycles apart.
        add_bits("101010", "000101", "000100");

        foreach (vecs[i]) begin
            apply(vecs[i].sclr, vecs[i].din);
            check("vec_ov", i, pdet_ov, vecs[i].exp_ov);
            check("vec_no", i, pdet_no, vecs[i].exp_no);
        end

        // Random stream with occasional resets against the window model.
        apply(1'b0, 1'b0);
        model_step(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic s;
            logic d;
            s = ($urandom_range(0, 39) != 0);
            // Bias toward alternating bits so matches are frequent.
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : ~in_data;
            apply(s, d);
            model_step(s, d);
            check("rnd_ov", i, pdet_ov, mdl_ov);
            check("rnd_no", i, pdet_no, mdl_no);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_1010.md
Name: pattern_1010

Overview:
Serial bit-stream pattern detector. Samples one bit of IN_DATA per CLK rising edge and asserts PDET for one cycle each time the sequence 1,0,1,0 (oldest first) has been received. Implemented as a Moore FSM with a registered output. Used as a frame-marker detector in the frame-detector datapath.

Parameters:
OVERLAP, 1, 1 = overlapping detection (the trailing "10" of a match may start the next match); 0 = non-overlapping (the detector restarts after a match).

Ports:
CLK  input  1  system clock; all logic on rising edge
SCLR  input  1  synchronous reset, active-low; sampled on CLK rising edge
IN_DATA  input  1  serial data bit, sampled every rising edge
PDET  output  1  pattern-detected flag, registered, one cycle per match

Behaviour:
- One clock; reset is synchronous and active-low. CLK and SCLR are the port names.
- SCLR=0 at a rising edge: state <= S0 and PDET = 0 from that edge. Reset has priority over IN_DATA.
- While SCLR stays 0, the FSM holds S0 and ignores IN_DATA.
- States, one-hot or binary (implementer's choice): S0 (nothing), S1 ("1"), S10 ("10"), S101 ("101"), S1010 (match).
- Transitions on each rising edge with SCLR=1:
  - S0: 1->S1, 0->S0
  - S1: 1->S1, 0->S10
  - S10: 1->S101, 0->S0
  - S101: 1->S1, 0->S1010
  - S1010, OVERLAP=1: 1->S101, 0->S0
  - S1010, OVERLAP=0: 1->S1, 0->S0
- Any unused or illegal state encoding returns to S0 on the next edge.
- PDET = (state == S1010). It is a Moore output driven from state flops, with no combinational path from IN_DATA.
- Latency: PDET goes high in the cycle directly after the rising edge that samples the final 0 of the pattern. It stays high for exactly one cycle per match.
- Back-to-back matches with OVERLAP=1: input 1,0,1,0,1,0 produces PDET pulses 2 cycles apart. Each pulse is one cycle wide.
- Reset mid-pattern: any partial match is discarded. Matching resumes from S0 on the first edge with SCLR=1.
- Reset while PDET=1: PDET is 0 after that edge.
- There is no enable input. Every rising edge with SCLR=1 consumes one bit.

Test Plan:
- Reset: hold SCLR=0 for 2 edges with IN_DATA toggling -> PDET=0 throughout; state S0.
- Single match: after reset, feed 0,0,1,0,1,0 -> PDET=1 for exactly one cycle, following the edge that samples the last 0; 0 otherwise.
- Mixed stream, OVERLAP=1: after reset, feed 0,0,1,0,1,1,0,0,1,1,0,1,0,1,0,1,1,0,0. Matches end on bits 12 and 14 (0-indexed), giving exactly two one-cycle PDET pulses 2 cycles apart. No pulse for the partial 1,0,1,1 at bits 2-5.
- Same stream, OVERLAP=0 -> exactly one PDET pulse, after bit 12; the bit-14 match is suppressed.
- Near-misses: feed 1,1,0,1,1,0,0,1,0,0 -> PDET stays 0.
- Reset mid-pattern: feed 1,0,1, pulse SCLR=0 for one edge, then feed 0 -> no PDET. Then feed 1,0,1,0 -> one PDET pulse.
